// File: rtl/xor_up_stream.sv
// Rate-side injector for the ASCON-128 permutation input: buffers one padded host
// block, XORs it into x0 on the controller strobe and captures ciphertext in PT mode.
module xor_up_stream #(
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clock_i,
  input  logic                 resetb_i,
  input  logic [4:0][63:0]     state_i,
  output logic [4:0][63:0]     state_o,
  input  logic                 ena_xor_up_i,
  input  logic                 mode_pt_i,
  input  logic [63:0]          data_i,
  input  logic                 data_valid_i,
  input  logic                 last_i,
  input  logic [3:0]           nbytes_i,
  output logic                 data_ready_o,
  output logic                 block_avail_o,
  output logic                 pad_pending_o,
  output logic                 phase_done_o,
  output logic [63:0]          cipher_o,
  output logic [3:0]           cipher_nbytes_o,
  output logic                 cipher_valid_o,
  input  logic                 cipher_ready_i,
  output logic                 underrun_o,
  output logic [CNT_W-1:0]     block_cnt_o
);

  typedef enum logic [1:0] {EMPTY, FULL, PAD} buf_state_e;

  buf_state_e       st_q, st_d;
  logic [63:0]      blk_q, blk_d;
  logic [3:0]       k_q, k_d;
  logic             last_pad_q, last_pad_d;
  logic             pad_next_q, pad_next_d;
  logic [63:0]      cipher_q, cipher_d;
  logic [3:0]       cnb_q, cnb_d;
  logic             cv_q, cv_d;
  logic             und_q, und_d;
  logic             pd_q, pd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             avail;
  logic             consume;
  logic [3:0]       k_in;
  logic [63:0]      x0_new;

  // Leading k bytes (big-endian) set, remainder clear.
  function automatic logic [63:0] byte_mask(input logic [3:0] k);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < 32'(k)) m[63 - 8*i -: 8] = 8'hFF;
    end
    return m;
  endfunction

  always_comb begin
    avail   = (st_q != EMPTY) &&
              (!mode_pt_i || (st_q == PAD) || !cv_q || cipher_ready_i);
    consume = ena_xor_up_i && avail;
    x0_new  = state_i[0] ^ blk_q;
    k_in    = last_i ? ((nbytes_i > 4'd8) ? 4'd8 : nbytes_i) : 4'd8;

    state_o = state_i;
    if (consume) state_o[0] = x0_new;

    st_d       = st_q;
    blk_d      = blk_q;
    k_d        = k_q;
    last_pad_d = last_pad_q;
    pad_next_d = pad_next_q;
    cipher_d   = cipher_q;
    cnb_d      = cnb_q;
    cv_d       = cv_q && !cipher_ready_i;
    und_d      = ena_xor_up_i && !avail;
    pd_d       = 1'b0;
    cnt_d      = cnt_q;

    if (consume && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

    case (st_q)
      EMPTY: begin
        if (data_valid_i) begin
          k_d        = k_in;
          last_pad_d = last_i && (k_in != 4'd8);
          pad_next_d = last_i && (k_in == 4'd8);
          blk_d      = data_i;
          if (k_in != 4'd8)
            blk_d = (data_i & byte_mask(k_in)) |
                    (64'h8000_0000_0000_0000 >> {k_in[2:0], 3'b000});
          st_d = FULL;
        end
      end
      FULL: begin
        if (consume) begin
          // Capture masks out the pad bit too, since it sits at byte k.
          if (mode_pt_i) begin
            cipher_d = x0_new & byte_mask(k_q);
            cnb_d    = k_q;
            if (k_q != 4'd0) cv_d = 1'b1;
          end
          if (pad_next_q) begin
            blk_d = 64'h8000_0000_0000_0000;
            st_d  = PAD;
          end else begin
            pd_d = last_pad_q;
            st_d = EMPTY;
          end
        end
      end
      PAD: begin
        if (consume) begin
          pd_d = 1'b1;
          st_d = EMPTY;
        end
      end
      default: st_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      st_q       <= EMPTY;
      blk_q      <= '0;
      k_q        <= '0;
      last_pad_q <= 1'b0;
      pad_next_q <= 1'b0;
      cipher_q   <= '0;
      cnb_q      <= '0;
      cv_q       <= 1'b0;
      und_q      <= 1'b0;
      pd_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      st_q       <= st_d;
      blk_q      <= blk_d;
      k_q        <= k_d;
      last_pad_q <= last_pad_d;
      pad_next_q <= pad_next_d;
      cipher_q   <= cipher_d;
      cnb_q      <= cnb_d;
      cv_q       <= cv_d;
      und_q      <= und_d;
      pd_q       <= pd_d;
      cnt_q      <= cnt_d;
    end
  end

  // Ready is held low while reset is asserted even though the buffer is empty.
  assign data_ready_o    = resetb_i && (st_q == EMPTY);
  assign block_avail_o   = avail;
  assign pad_pending_o   = (st_q == PAD);
  assign phase_done_o    = pd_q;
  assign cipher_o        = cipher_q;
  assign cipher_nbytes_o = cnb_q;
  assign cipher_valid_o  = cv_q;
  assign underrun_o      = und_q;
  assign block_cnt_o     = cnt_q;

endmodule

// File: tb/tb_xor_up_stream.sv
// Randomized self-checking bench for xor_up_stream against a queue-based block model.
module tb_xor_up_stream;

  logic              clk = 1'b0;
  logic              resetb;
  logic [4:0][63:0]  st_in, st_out;
  logic              ena, mode, data_valid, last, cready;
  logic [63:0]       data;
  logic [3:0]        nbytes;
  logic              data_ready_o, block_avail_o, pad_pending_o, phase_done_o;
  logic [63:0]       cipher_o;
  logic [3:0]        cipher_nbytes_o;
  logic              cipher_valid_o, underrun_o;
  logic [7:0]        block_cnt_o;

  always #5 clk = ~clk;

  xor_up_stream #(.CNT_W(8)) dut (
    .clock_i(clk), .resetb_i(resetb), .state_i(st_in), .state_o(st_out),
    .ena_xor_up_i(ena), .mode_pt_i(mode), .data_i(data), .data_valid_i(data_valid),
    .last_i(last), .nbytes_i(nbytes), .data_ready_o(data_ready_o),
    .block_avail_o(block_avail_o), .pad_pending_o(pad_pending_o),
    .phase_done_o(phase_done_o), .cipher_o(cipher_o), .cipher_nbytes_o(cipher_nbytes_o),
    .cipher_valid_o(cipher_valid_o), .cipher_ready_i(cready), .underrun_o(underrun_o),
    .block_cnt_o(block_cnt_o)
  );

  typedef struct {
    logic [63:0] blk;
    int          k;
    bit          is_pad;
    bit          phase_end;
  } ent_t;

  ent_t        pend[$];
  bit          m_cv, m_und, m_pd;
  logic [63:0] m_co;
  int          m_cn, m_cnt;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] obs_x0;
  logic        obs_avail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] keep_bytes(input logic [63:0] x, input int k);
    if (k == 0) return 64'd0;
    return (x >> (64 - 8*k)) << (64 - 8*k);
  endfunction

  function automatic logic [63:0] pad_block(input logic [63:0] d, input int k);
    if (k == 0) return 64'h8000_0000_0000_0000;
    return keep_bytes(d, k) | (64'h80 << (56 - 8*k));
  endfunction

  task automatic model_reset();
    pend.delete();
    m_cv = 0; m_und = 0; m_pd = 0; m_co = '0; m_cn = 0; m_cnt = 0;
  endtask

  task automatic step(input bit v, input logic [63:0] d, input bit l, input logic [3:0] nb,
                      input bit en, input bit md, input bit cr, input logic [63:0] x0);
    ent_t        f, e;
    bit          avail, cons, acc;
    logic [63:0] ex0;
    int          k;
    @(negedge clk);
    data_valid = v; data = d; last = l; nbytes = nb; ena = en; mode = md; cready = cr;
    st_in[0] = x0;
    for (int i = 1; i < 5; i++) st_in[i] = {$urandom, $urandom};
    #1;
    avail = (pend.size() != 0) && (!md || pend[0].is_pad || !m_cv || cr);
    cons  = en && avail;
    acc   = v && (pend.size() == 0);
    chk("data_ready", 64'(data_ready_o), 64'(pend.size() == 0));
    chk("block_avail", 64'(block_avail_o), 64'(avail));
    chk("pad_pending", 64'(pad_pending_o), 64'((pend.size() != 0) && pend[0].is_pad));
    ex0 = cons ? (x0 ^ pend[0].blk) : x0;
    chk("state_x0", st_out[0], ex0);
    for (int i = 1; i < 5; i++) chk("state_xn", st_out[i], st_in[i]);
    obs_x0 = st_out[0];
    obs_avail = block_avail_o;
    @(posedge clk);
    #1;
    m_und = en && !avail;
    m_pd  = 0;
    if (m_cv && cr) m_cv = 0;
    if (cons) begin
      f = pend.pop_front();
      m_pd = f.phase_end;
      if (md && !f.is_pad) begin
        m_co = keep_bytes(ex0, f.k);
        m_cn = f.k;
        if (f.k != 0) m_cv = 1;
      end
      if (m_cnt < 255) m_cnt++;
    end
    if (acc) begin
      k = l ? ((nb > 8) ? 8 : int'(nb)) : 8;
      e.is_pad = 0;
      e.k = k;
      e.blk = (l && k < 8) ? pad_block(d, k) : d;
      e.phase_end = l && (k < 8);
      pend.push_back(e);
      if (l && k == 8) begin
        e.blk = 64'h8000_0000_0000_0000; e.k = 0; e.is_pad = 1; e.phase_end = 1;
        pend.push_back(e);
      end
    end
    chk("cipher_valid", 64'(cipher_valid_o), 64'(m_cv));
    chk("cipher_o", cipher_o, m_co);
    chk("cipher_nbytes", 64'(cipher_nbytes_o), 64'(m_cn));
    chk("underrun", 64'(underrun_o), 64'(m_und));
    chk("phase_done", 64'(phase_done_o), 64'(m_pd));
    chk("block_cnt", 64'(block_cnt_o), 64'(m_cnt));
  endtask

  task automatic idle(input bit cr);
    step(0, '0, 0, '0, 0, 0, cr, {$urandom, $urandom});
  endtask

  initial begin
    resetb = 0;
    ena = 0; mode = 0; data_valid = 0; last = 0; cready = 0; data = '0; nbytes = '0;
    st_in = '0;
    model_reset();
    #23;
    chk("rst_data_ready", 64'(data_ready_o), 64'd0);
    chk("rst_cipher_valid", 64'(cipher_valid_o), 64'd0);
    chk("rst_block_cnt", 64'(block_cnt_o), 64'd0);
    @(negedge clk);
    resetb = 1;
    #1;
    chk("rel_data_ready", 64'(data_ready_o), 64'd1);

    // AD single short block
    step(1, 64'h0123_4567_89AB_CDEF, 1, 4'd3, 0, 0, 0, '0);
    step(0, '0, 0, '0, 1, 0, 0, '0);
    chk("ad_x0", obs_x0, 64'h0123_4580_0000_0000);
    chk("ad_phase_done", 64'(phase_done_o), 64'd1);
    chk("ad_cnt", 64'(block_cnt_o), 64'd1);
    idle(0);

    // PT full block, cipher held until ready
    step(1, 64'hFFFF_0000_FFFF_0000, 0, 4'd0, 0, 1, 0, '0);
    step(0, '0, 0, '0, 1, 1, 0, 64'h0F0F_0F0F_0F0F_0F0F);
    chk("pt_cipher", cipher_o, 64'hF0F0_0F0F_F0F0_0F0F);
    chk("pt_nbytes", 64'(cipher_nbytes_o), 64'd8);
    idle(0);
    chk("pt_hold", 64'(cipher_valid_o), 64'd1);

    // Backpressure: block buffered, cipher stuck
    step(1, {$urandom, $urandom}, 0, 4'd0, 0, 1, 0, '0);
    step(0, '0, 0, '0, 1, 1, 0, 64'h1234_5678_9ABC_DEF0);
    chk("bp_avail", 64'(obs_avail), 64'd0);
    chk("bp_x0", obs_x0, 64'h1234_5678_9ABC_DEF0);
    chk("bp_underrun", 64'(underrun_o), 64'd1);
    step(0, '0, 0, '0, 1, 1, 1, '0);
    chk("bp_release", 64'(obs_avail), 64'd1);
    idle(1);

    // Last block with 8 bytes generates a pad block
    step(1, {$urandom, $urandom}, 1, 4'd8, 0, 1, 1, '0);
    step(0, '0, 0, '0, 1, 1, 1, {$urandom, $urandom});
    chk("pad_pd_first", 64'(phase_done_o), 64'd0);
    chk("pad_pending", 64'(pad_pending_o), 64'd1);
    step(0, '0, 0, '0, 1, 1, 1, '0);
    chk("pad_x0", obs_x0, 64'h8000_0000_0000_0000);
    chk("pad_pd_second", 64'(phase_done_o), 64'd1);
    chk("pad_no_cipher", 64'(cipher_valid_o), 64'd0);

    // Underrun while empty
    step(0, '0, 0, '0, 1, 0, 0, 64'hDEAD_BEEF_0000_1111);
    chk("empty_x0", obs_x0, 64'hDEAD_BEEF_0000_1111);
    chk("empty_underrun", 64'(underrun_o), 64'd1);

    // Reset while FULL with cipher valid
    step(1, {$urandom, $urandom}, 0, 4'd0, 0, 1, 0, '0);
    step(0, '0, 0, '0, 1, 1, 0, {$urandom, $urandom});
    step(1, {$urandom, $urandom}, 0, 4'd0, 0, 1, 0, '0);
    @(negedge clk);
    #2;
    resetb = 0;
    #1;
    chk("mid_data_ready", 64'(data_ready_o), 64'd0);
    chk("mid_block_avail", 64'(block_avail_o), 64'd0);
    chk("mid_cipher_valid", 64'(cipher_valid_o), 64'd0);
    chk("mid_cipher_o", cipher_o, 64'd0);
    chk("mid_block_cnt", 64'(block_cnt_o), 64'd0);
    model_reset();
    #4;
    resetb = 1;
    idle(0);
    chk("post_data_ready", 64'(data_ready_o), 64'd1);

    // Random traffic, long enough to saturate the counter
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) == 0,
           4'($urandom_range(0, 8)), $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 2) != 0, {$urandom, $urandom});
    end
    chk("saturated_cnt", 64'(block_cnt_o), 64'd255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
